afifo_rd_ddr_burst_wr: RTL

- Consumer stage on the read side of the 16-in/64-out async FIFO (512 deep on the write side, 128 x 64-bit words on the read side).
- Waits until the FIFO holds a full burst, pops 64-bit words, and issues incrementing AXI-style write bursts (address and data channels) to the DDR controller port.
- Bursts are frame-based: one frame is FRAME_BEATS words written from BASE_ADDR upward. The final burst is shortened if the frame is not a multiple of BURST_LEN.

---
 rtl/afifo_burst_pkg.sv | 18 +
 rtl/rd_skid_buf_2.sv | 40 ++++
 rtl/afifo_rd_ddr_burst_wr.sv | 130 +++++++++++++
 3 files changed

// File: rtl/afifo_burst_pkg.sv
// Shared types for the async-FIFO read-side burst consumers.
// Holds the burst FSM encoding and beat/length helpers.
package afifo_burst_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LVL,
      ADDR,
      DATA
   } state_t;

   typedef logic [7:0] aw_len_t;

   function automatic int bytes_per_beat(int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/rd_skid_buf_2.sv
// Two-entry FIFO that catches the registered FIFO read data.
// Shared by the FIFO-consumer stages on the read side.
module rd_skid_buf_2 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem0;
   logic [WIDTH-1:0] mem1;
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem0   <= '0;
         mem1   <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            if (wr_ptr) mem1 <= din;
            else        mem0 <= din;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = rd_ptr ? mem1 : mem0;

endmodule

// File: rtl/afifo_rd_ddr_burst_wr.sv
// Drains 64-bit words from the async FIFO read side into
// incrementing DDR write bursts, one frame per frame_start.
module afifo_rd_ddr_burst_wr
   import afifo_burst_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 28,
   parameter int LEVEL_WIDTH = 8,
   parameter int BURST_LEN   = 16,
   parameter int FRAME_BEATS = 76800,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst,
   input  logic                   frame_start,
   output logic                   frame_done,
   output logic                   busy,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   input  logic                   fifo_rd_empty,
   input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
   output logic                   fifo_rd_en,
   output logic                   aw_valid,
   input  logic                   aw_ready,
   output logic [ADDR_WIDTH-1:0]  aw_addr,
   output logic [7:0]             aw_len,
   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [DATA_WIDTH-1:0]  w_data,
   output logic                   w_last
);

   localparam int BYTES_PER_BEAT = bytes_per_beat(DATA_WIDTH);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [31:0]           remain;
   aw_len_t               cur_len;
   aw_len_t               next_len;
   aw_len_t               popped;
   aw_len_t               beat_cnt;
   logic                  inflight;
   logic [1:0]            skid_count;
   logic                  lvl_ok;
   logic                  beat;
   logic                  last_beat;

   assign next_len = (remain < 32'(BURST_LEN)) ? remain[7:0]
                                               : 8'(BURST_LEN);
   assign lvl_ok   = 32'(fifo_rd_level) >= 32'(next_len);

   // inflight covers the pop whose data lands next cycle
   assign fifo_rd_en = (state == DATA) && !fifo_rd_empty
                     && (popped < cur_len)
                     && (({1'b0, skid_count} + {2'b0, inflight}) < 3'd2);

   assign w_valid    = skid_count != 2'd0;
   assign beat       = w_valid && w_ready;
   assign w_last     = w_valid && (beat_cnt == cur_len - 8'd1);
   assign last_beat  = beat && w_last;
   assign frame_done = (state == DATA) && last_beat
                     && (remain == 32'(cur_len));
   assign busy       = state != IDLE;

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state    <= IDLE;
         addr_cnt <= '0;
         remain   <= '0;
         cur_len  <= '0;
         popped   <= '0;
         beat_cnt <= '0;
         inflight <= 1'b0;
         aw_valid <= 1'b0;
         aw_addr  <= '0;
         aw_len   <= '0;
      end else begin
         inflight <= fifo_rd_en;
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  addr_cnt <= BASE_ADDR;
                  remain   <= 32'(FRAME_BEATS);
                  state    <= WAIT_LVL;
               end
            end
            WAIT_LVL: begin
               if (lvl_ok) begin
                  cur_len  <= next_len;
                  aw_addr  <= addr_cnt;
                  aw_len   <= next_len - 8'd1;
                  aw_valid <= 1'b1;
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (aw_ready) begin
                  aw_valid <= 1'b0;
                  popped   <= '0;
                  beat_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (fifo_rd_en) popped <= popped + 8'd1;
               if (beat) beat_cnt <= beat_cnt + 8'd1;
               if (last_beat) begin
                  addr_cnt <= addr_cnt
                            + ADDR_WIDTH'(32'(cur_len) * BYTES_PER_BEAT);
                  remain   <= remain - 32'(cur_len);
                  state    <= (remain == 32'(cur_len)) ? IDLE : WAIT_LVL;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   rd_skid_buf_2 #(
      .WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk  (rd_clk),
      .rst  (rd_rst),
      .push (inflight),
      .pop  (beat),
      .din  (fifo_rd_data),
      .head (w_data),
      .count(skid_count)
   );

endmodule
